// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state encoding
// and default memory geometry / reset PC.
package fetch_seq_pkg;

   localparam int ADDR_W_DEF   = 10;
   localparam int DATA_W_DEF   = 32;
   localparam int RESET_PC_DEF = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FETCH = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter for the fetch sequencer: redirect load (target+1), increment
// with natural wrap, restart to the reset PC, otherwise hold.
module fetch_pc #(
   parameter int                ADDR_W   = 10,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_restart,
   input  logic              i_inc,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   output logic [ADDR_W-1:0] o_pc
);

   localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_nxt;

   // Next-PC selection; redirect already issues its target, so resume one past it
   always_comb begin
      w_pc_nxt = r_pc;
      if (i_redirect) begin
         w_pc_nxt = i_redirect_pc + PC_ONE;
      end else if (i_inc) begin
         w_pc_nxt = r_pc + PC_ONE;
      end else if (i_restart) begin
         w_pc_nxt = RESET_PC;
      end else begin
         w_pc_nxt = r_pc;
      end
   end

   // PC register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_pc_nxt;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the instruction RAM port, arbitrating loader writes against fetch, and
// delivers fetched words to decode. Optional macro FETCH_COUNT_EN adds o_fetch_count.
module fetch_sequencer
   import fetch_seq_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int RESET_PC = RESET_PC_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load_req,
   input  logic [ADDR_W-1:0] i_load_addr,
   input  logic [DATA_W-1:0] i_load_data,
   output logic              o_load_gnt,
   input  logic              i_run,
   input  logic              i_stall,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   input  logic              i_halt,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_we,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic [DATA_W-1:0] o_instr,
   output logic [ADDR_W-1:0] o_instr_pc,
   output logic              o_instr_valid,
   output logic [1:0]        o_state
`ifdef FETCH_COUNT_EN
   ,output logic [31:0]      o_fetch_count
`endif
);

   localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

   state_e            r_state;
   state_e            w_state_nxt;
   logic              r_iss_vld;
   logic [ADDR_W-1:0] r_iss_addr;
   logic [DATA_W-1:0] r_instr;
   logic [ADDR_W-1:0] r_instr_pc;
   logic              r_instr_valid;

   logic              w_iss_vld_nxt;
   logic [ADDR_W-1:0] w_iss_addr_nxt;
   logic [DATA_W-1:0] w_instr_nxt;
   logic [ADDR_W-1:0] w_instr_pc_nxt;
   logic              w_instr_valid_nxt;
   logic [ADDR_W-1:0] w_pc;
   logic              w_pc_inc;
   logic              w_pc_redirect;
   logic              w_pc_restart;
   logic [ADDR_W-1:0] w_mem_addr;
   logic              w_mem_we;
   logic              w_load_gnt;
`ifdef FETCH_COUNT_EN
   logic              w_cnt_clr;
   logic [31:0]       r_fetch_count;
`endif

   fetch_pc #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC_V)
   ) u_pc (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_restart     (w_pc_restart),
      .i_inc         (w_pc_inc),
      .i_redirect    (w_pc_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_pc          (w_pc)
   );

   // Next-state, memory-port arbitration and issue/capture control
   always_comb begin
      w_state_nxt       = r_state;
      w_iss_vld_nxt     = r_iss_vld;
      w_iss_addr_nxt    = r_iss_addr;
      w_instr_nxt       = r_instr;
      w_instr_pc_nxt    = r_instr_pc;
      w_instr_valid_nxt = r_instr_valid;
      w_pc_inc          = 1'b0;
      w_pc_redirect     = 1'b0;
      w_pc_restart      = 1'b0;
      w_mem_addr        = w_pc;
      w_mem_we          = 1'b0;
      w_load_gnt        = 1'b0;
`ifdef FETCH_COUNT_EN
      w_cnt_clr         = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (i_load_req) begin
               w_state_nxt = ST_LOAD;
            end else if (i_run) begin
               w_state_nxt  = ST_FETCH;
               w_pc_restart = 1'b1;
`ifdef FETCH_COUNT_EN
               w_cnt_clr    = 1'b1;
`endif
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_LOAD: begin
            w_load_gnt = i_load_req;
            w_mem_we   = i_load_req;
            w_mem_addr = i_load_addr;
            if (i_load_req) begin
               w_state_nxt = ST_LOAD;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (i_halt || !i_run) begin
               w_state_nxt       = ST_HALT;
               w_iss_vld_nxt     = 1'b0;
               w_instr_valid_nxt = 1'b0;
               w_mem_addr        = r_iss_addr;
            end else if (i_redirect) begin
               // Squash the in-flight word and issue the target immediately
               w_pc_redirect     = 1'b1;
               w_mem_addr        = i_redirect_pc;
               w_iss_addr_nxt    = i_redirect_pc;
               w_iss_vld_nxt     = 1'b1;
               w_instr_valid_nxt = 1'b0;
            end else if (i_stall) begin
               // Re-present the in-flight address so its data is still there on release
               w_mem_addr = r_iss_addr;
            end else begin
               w_mem_addr     = w_pc;
               w_iss_addr_nxt = w_pc;
               w_iss_vld_nxt  = 1'b1;
               w_pc_inc       = 1'b1;
               if (r_iss_vld) begin
                  w_instr_nxt       = i_mem_rdata;
                  w_instr_pc_nxt    = r_iss_addr;
                  w_instr_valid_nxt = 1'b1;
               end else begin
                  w_instr_valid_nxt = 1'b0;
               end
            end
         end
         ST_HALT: begin
            w_instr_valid_nxt = 1'b0;
            w_mem_addr        = r_iss_addr;
            if (!i_run) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_HALT;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, issue tracking and decode-facing output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_iss_vld     <= 1'b0;
         r_iss_addr    <= '0;
         r_instr       <= '0;
         r_instr_pc    <= '0;
         r_instr_valid <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_iss_vld     <= w_iss_vld_nxt;
         r_iss_addr    <= w_iss_addr_nxt;
         r_instr       <= w_instr_nxt;
         r_instr_pc    <= w_instr_pc_nxt;
         r_instr_valid <= w_instr_valid_nxt;
      end
   end

`ifdef FETCH_COUNT_EN
   // Saturating count of words accepted by decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_count <= 32'd0;
      end else if (w_cnt_clr) begin
         r_fetch_count <= 32'd0;
      end else if (r_instr_valid && !i_stall && (r_fetch_count != 32'hFFFF_FFFF)) begin
         r_fetch_count <= r_fetch_count + 32'd1;
      end else begin
         r_fetch_count <= r_fetch_count;
      end
   end

   assign o_fetch_count = r_fetch_count;
`endif

   assign o_load_gnt    = w_load_gnt;
   assign o_mem_we      = w_mem_we;
   assign o_mem_addr    = w_mem_addr;
   assign o_mem_wdata   = i_load_data;
   assign o_instr       = r_instr;
   assign o_instr_pc    = r_instr_pc;
   assign o_instr_valid = r_instr_valid;
   assign o_state       = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural 1024x32 synchronous RAM
// and a scoreboard of words decode is expected to accept.
module tb_fetch_sequencer;

   logic        clk;
   logic        rst_n;
   logic        load_req;
   logic [9:0]  load_addr;
   logic [31:0] load_data;
   logic        load_gnt;
   logic        run;
   logic        stall;
   logic        redirect;
   logic [9:0]  redirect_pc;
   logic        halt;
   logic [9:0]  mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [31:0] instr;
   logic [9:0]  instr_pc;
   logic        instr_valid;
   logic [1:0]  state;
`ifdef FETCH_COUNT_EN
   logic [31:0] fetch_count;
`endif

   logic [31:0] mem [0:1023];
   logic [41:0] sb [$];
   int          n_cmp;
   int          n_mis;

   fetch_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_load_req    (load_req),
      .i_load_addr   (load_addr),
      .i_load_data   (load_data),
      .o_load_gnt    (load_gnt),
      .i_run         (run),
      .i_stall       (stall),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .i_halt        (halt),
      .o_mem_addr    (mem_addr),
      .o_mem_we      (mem_we),
      .o_mem_wdata   (mem_wdata),
      .i_mem_rdata   (mem_rdata),
      .o_instr       (instr),
      .o_instr_pc    (instr_pc),
      .o_instr_valid (instr_valid),
      .o_state       (state)
`ifdef FETCH_COUNT_EN
      ,.o_fetch_count (fetch_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port RAM, read data one cycle after the address
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 | i;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Decode side: each accepted word must be the next one the scoreboard predicts
   always @(negedge clk) begin
      logic [41:0] exp_w;
      if (rst_n && instr_valid && !stall) begin
         if (sb.size() > 0) exp_w = sb.pop_front();
         else               exp_w = '1;
         check("accepted_word", {instr_pc, instr}, exp_w);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] vals [4];
      int          gnt_cnt;
      logic        got;
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
      n_cmp = 0; n_mis = 0;
      rst_n = 1'b0; load_req = 1'b0; load_addr = 10'd0; load_data = 32'd0;
      run = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 10'd0; halt = 1'b0;

      #3;
      check("rst_state", state, 2'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", instr_pc, 10'd0);
      check("rst_valid", instr_valid, 1'b0);
      check("rst_we", mem_we, 1'b0);
      check("rst_gnt", load_gnt, 1'b0);
`ifdef FETCH_COUNT_EN
      check("rst_count", fetch_count, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Program load of four words
      load_req = 1'b1;
      gnt_cnt  = 0;
      for (int k = 0; k < 4; k++) begin
         load_addr = 10'(k);
         load_data = vals[k];
         got = 1'b0;
         for (int w = 0; w < 8 && !got; w++) begin
            @(negedge clk);
            if (load_gnt) begin
               got = 1'b1;
               gnt_cnt++;
               check("load_addr", mem_addr, 64'(k));
               check("load_we", mem_we, 1'b1);
            end
         end
         check("load_gnt_seen", got, 1'b1);
         tick();
      end
      load_req = 1'b0;
      @(negedge clk);
      check("load_gnt_drop", load_gnt, 1'b0);
      check("load_gnt_cycles", gnt_cnt, 4);
      tick();
      check("load_to_idle", state, 2'd0);
      for (int k = 0; k < 4; k++) check("load_mem", mem[k], vals[k]);

      // Basic fetch 0..3, halted after the fourth word
      sb.push_back({10'd0, 32'h11}); sb.push_back({10'd1, 32'h22});
      sb.push_back({10'd2, 32'h33}); sb.push_back({10'd3, 32'h44});
      run = 1'b1;
      tick();
      check("fetch_entry", state, 2'd2);
      check("lat_valid_c0", instr_valid, 1'b0);
      tick();
      check("lat_valid_c1", instr_valid, 1'b0);
      tick();
      check("lat_valid_c2", instr_valid, 1'b1);
      tick(); tick(); tick();
      halt = 1'b1;
      tick();
      check("halt_state", state, 2'd3);
      check("halt_valid", instr_valid, 1'b0);
`ifdef FETCH_COUNT_EN
      check("count_after_4", fetch_count, 32'd4);
`endif
      halt = 1'b0; run = 1'b0;
      tick();
      check("halt_to_idle", state, 2'd0);
      check("sb_drained_a", sb.size(), 0);

      // Stall, redirect with wrap, redirect+stall, halt+redirect
      sb.push_back({10'd0, 32'h11}); sb.push_back({10'd1, 32'h22});
      sb.push_back({10'd2, 32'h33});
      sb.push_back({10'h3FE, 32'hA000_03FE}); sb.push_back({10'h3FF, 32'hA000_03FF});
      sb.push_back({10'd0, 32'h11});
      sb.push_back({10'h010, 32'hA000_0010}); sb.push_back({10'h011, 32'hA000_0011});
      run = 1'b1;
      tick(); tick(); tick(); tick();
      stall = 1'b1;
      for (int s = 0; s < 3; s++) begin
         tick();
         check("stall_instr", instr, 32'h22);
         check("stall_pc", instr_pc, 10'd1);
         check("stall_valid", instr_valid, 1'b1);
      end
      stall = 1'b0;
      tick();
      check("post_stall_pc", instr_pc, 10'd2);
      redirect = 1'b1; redirect_pc = 10'h3FE;
      tick();
      check("redirect_bubble", instr_valid, 1'b0);
      redirect = 1'b0;
      tick(); tick(); tick();
      check("wrap_pc", instr_pc, 10'd0);
      tick();
      stall = 1'b1; redirect = 1'b1; redirect_pc = 10'h010;
      tick();
      check("redir_stall_valid", instr_valid, 1'b0);
      check("redir_stall_state", state, 2'd2);
      stall = 1'b0; redirect = 1'b0;
      tick(); tick();
      halt = 1'b1; redirect = 1'b1; redirect_pc = 10'h200;
      tick();
      check("halt_redir_state", state, 2'd3);
      check("halt_redir_valid", instr_valid, 1'b0);
      halt = 1'b0; redirect = 1'b0;
      tick();
      check("halt_hold_state", state, 2'd3);
      check("halt_hold_valid", instr_valid, 1'b0);
      run = 1'b0;
      tick();
      check("halt_release", state, 2'd0);
      check("sb_drained_b", sb.size(), 0);

      // Loader request during fetch is ignored
      sb.push_back({10'd0, 32'h11}); sb.push_back({10'd1, 32'h22});
      run = 1'b1;
      tick();
      load_req = 1'b1; load_addr = 10'd0; load_data = 32'hDEAD_BEEF;
      @(negedge clk);
      check("fetch_load_gnt", load_gnt, 1'b0);
      check("fetch_load_we", mem_we, 1'b0);
      tick(); tick(); tick();
      halt = 1'b1; load_req = 1'b0;
      tick();
      check("e_halt_state", state, 2'd3);
      halt = 1'b0; run = 1'b0;
      tick();
      check("e_idle", state, 2'd0);
      check("mem_untouched", mem[0], 32'h11);
      check("sb_drained_c", sb.size(), 0);

      // Asynchronous reset in the middle of fetch
      sb.push_back({10'd0, 32'h11});
      run = 1'b1;
      tick(); tick(); tick(); tick();
      check("pre_rst_valid", instr_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_state", state, 2'd0);
      check("arst_instr", instr, 32'd0);
      check("arst_pc", instr_pc, 10'd0);
      check("arst_valid", instr_valid, 1'b0);
      check("arst_we", mem_we, 1'b0);
      check("arst_gnt", load_gnt, 1'b0);
`ifdef FETCH_COUNT_EN
      check("arst_count", fetch_count, 32'd0);
`endif
      run = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_state", state, 2'd0);
      check("sb_drained_d", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller that owns the 1024-word instruction memory port (address, write enable, write data) and shares it between a program loader and the fetch engine.
- Replaces the free-running program counter.
- Sequences fetch with start, stall, redirect and halt control, and presents fetched words with their PC and a valid flag to decode.
- The memory is a synchronous single-port RAM: read data is valid the cycle after the address is presented.

Parameters:
- ADDR_W, 10: instruction memory address width in words.
- DATA_W, 32: instruction width.
- RESET_PC, 0: PC value loaded at reset and on IDLE->FETCH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous assert, active-low
- load_req  in  1  loader requests a write this cycle
- load_addr  in  ADDR_W  loader write address
- load_data  in  DATA_W  loader write data
- load_gnt  out  1  write accepted this cycle
- run  in  1  level: start/continue fetching
- stall  in  1  decode cannot accept; freeze fetch
- redirect  in  1  one-cycle pulse: jump to redirect_pc
- redirect_pc  in  ADDR_W  new fetch address
- halt  in  1  pulse: stop fetching
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data (1-cycle latency)
- instr  out  DATA_W  fetched instruction
- instr_pc  out  ADDR_W  address of instr
- instr_valid  out  1  instr/instr_pc valid
- state  out  2  current FSM state

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, pc=RESET_PC, iss_vld=0, iss_addr=0.
  - instr=0, instr_pc=0, instr_valid=0.
  - mem_we=0, load_gnt=0.
- States: IDLE=0, LOAD=1, FETCH=2, HALT=3.
- IDLE:
  - load_req -> LOAD; else run -> FETCH (pc<=RESET_PC).
  - load_req has priority over run.
- LOAD:
  - Outputs combinational: load_gnt=load_req, mem_we=load_req, mem_addr=load_addr, mem_wdata=load_data.
  - One word written per cycle while load_req=1.
  - load_req=0 -> IDLE.
- FETCH:
  - mem_we=0, load_gnt=0; load_req ignored.
  - Not stalled: mem_addr=pc, iss_addr<=pc, iss_vld<=1, pc<=pc+1 (wraps 2^ADDR_W-1 -> 0).
  - Capture: when iss_vld=1 and not stalled, instr<=mem_rdata, instr_pc<=iss_addr, instr_valid<=1.
  - Latency: address at cycle N -> instr_valid at cycle N+2.
  - Stalled (stall=1): mem_addr=iss_addr, so the RAM re-reads the in-flight word. pc, iss_*, instr, instr_pc and instr_valid all hold. No word is lost or duplicated on release.
  - redirect (priority over stall and normal issue): pc<=redirect_pc+1, mem_addr=redirect_pc, iss_addr<=redirect_pc, iss_vld<=1, instr_valid<=0. The in-flight word is squashed.
  - halt (priority over redirect): -> HALT; iss_vld<=0, instr_valid<=0.
  - run=0 behaves as halt.
- HALT:
  - No issue; instr_valid=0; pc holds.
  - run=0 -> IDLE. A fresh run then restarts at RESET_PC.
- Async reset mid-LOAD: the write in that cycle is not guaranteed; load_gnt drops immediately.
- mem_wdata = load_data in all states; it is qualified only by mem_we.

Optional Feature:
FETCH_COUNT_EN
- Defined: adds output fetch_count (32 bits). It increments on every cycle with instr_valid=1 and stall=0, saturates at 0xFFFFFFFF, clears on reset and on IDLE->FETCH.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package fetch_seq_pkg:
  - state encodings IDLE/LOAD/FETCH/HALT (2-bit typedef);
  - default ADDR_W/DATA_W constants;
  - RESET_PC.
- Sub-module fetch_pc: PC register with increment/wrap, hold, and redirect load. The FSM, arbitration and capture stay in fetch_sequencer.

Test Plan:
- Load 4 words at 0..3 (0x11,0x22,0x33,0x44), then run=1 -> load_gnt=1 for 4 cycles; instr_valid rises 2 cycles after FETCH entry; instr/instr_pc sequence is 0x11/0, 0x22/1, 0x33/2, 0x44/3.
- stall=1 for 3 cycles while instr_pc=1 -> instr holds 0x22/1; after release the next word is 0x33/2, with no skip and no repeat.
- redirect with redirect_pc=0x3FE while instr_pc=2 -> one cycle instr_valid=0; then 0x3FE, 0x3FF, 0x000 (wrap).
- redirect and stall in the same cycle -> redirect taken; halt and redirect in the same cycle -> HALT, instr_valid=0.
- load_req=1 during FETCH -> load_gnt=0, mem_we=0; memory contents unchanged.
- rst_n=0 asynchronously mid-FETCH -> all outputs return to reset values before the next clk edge; state=IDLE. With FETCH_COUNT_EN, fetch_count=0 after reset and equals 4 after the first scenario.
